// File: rtl/arbitro_enrutamiento_param_if.sv
// rtl/arbitro_enrutamiento_param_if.sv - VC-bank / destination-bank bundle for the parametrised arbiter
interface arbitro_enrutamiento_param_if #(
    parameter int DATA_W   = 6,
    parameter int NUM_VC   = 2,
    parameter int NUM_DEST = 4,
    parameter int CNT_W    = 8
);
    // VC FIFO bank side: first-word-fall-through heads and empty flags
    logic [NUM_VC*DATA_W-1:0]   vc_data;
    logic [NUM_VC-1:0]          vc_empty;
    logic [NUM_VC-1:0]          vc_pop;

    // Destination FIFO bank side: per-destination pause and registered pushes
    logic [NUM_DEST-1:0]        dest_pause;
    logic [NUM_DEST*DATA_W-1:0] d_out;
    logic [NUM_DEST-1:0]        d_push;

    // Status
    logic [NUM_VC*CNT_W-1:0]    vc_count;
    logic                       idle;

    // Environment that feeds the arbiter and absorbs its pushes
    modport master (
        output vc_data, vc_empty, dest_pause,
        input  vc_pop, d_out, d_push, vc_count, idle
    );

    // The arbiter itself
    modport slave (
        input  vc_data, vc_empty, dest_pause,
        output vc_pop, d_out, d_push, vc_count, idle
    );
endinterface

// File: rtl/arbitro_enrutamiento_param.sv
// rtl/arbitro_enrutamiento_param.sv - NUM_VC to NUM_DEST arbiter/router, strict or round-robin
module arbitro_enrutamiento_param #(
    parameter int DATA_W    = 6,
    parameter int NUM_VC    = 2,
    parameter int NUM_DEST  = 4,
    parameter int DEST_BITS = $clog2(NUM_DEST),
    parameter int RR_MODE   = 0,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    arbitro_enrutamiento_param_if.slave bus
);
    localparam int               PTR_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam logic [PTR_W-1:0] LAST_VC = PTR_W'(NUM_VC - 1);

    // Per-VC decode and grant
    logic [DEST_BITS-1:0]       vc_dest [NUM_VC];
    logic [NUM_VC-1:0]          eligible;
    logic [NUM_VC-1:0]          upper_elig;
    logic [NUM_VC-1:0]          pick_set;
    logic                       grant_valid;
    logic [PTR_W-1:0]           grant_idx;
    logic [DATA_W-1:0]          grant_word;
    logic [DEST_BITS-1:0]       grant_dest;
    logic [NUM_VC-1:0]          pop;

    // Registered state and next-state
    logic [NUM_DEST*DATA_W-1:0] d_out_q,  d_out_d;
    logic [NUM_DEST-1:0]        d_push_q, d_push_d;
    logic [NUM_VC*CNT_W-1:0]    cnt_q,    cnt_d;
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic                       idle_q,   idle_d;

    // A VC is eligible when it has a head word and that word's destination is not paused
    always_comb begin
        vc_dest  = '{default: '0};
        eligible = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            vc_dest[i]  = bus.vc_data[i*DATA_W + DATA_W - DEST_BITS +: DEST_BITS];
            eligible[i] = ~bus.vc_empty[i] & ~bus.dest_pause[vc_dest[i]];
        end
    end

    // Eligible VCs at or above the round-robin pointer; searched before wrapping to the bottom
    always_comb begin
        upper_elig = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            upper_elig[i] = eligible[i] & (i >= int'(rr_ptr_q));
        end
    end

    // Lowest set bit of the candidate set wins; the RR wrap falls out of using the full set
    always_comb begin
        pick_set = eligible;
        if ((RR_MODE != 0) && (|upper_elig)) begin
            pick_set = upper_elig;
        end
        grant_valid = |pick_set;
        grant_idx   = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (pick_set[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    assign grant_word = bus.vc_data[grant_idx*DATA_W +: DATA_W];
    assign grant_dest = grant_word[DATA_W-1 -: DEST_BITS];

    // Pop is combinational so the FWFT FIFO advances on the same edge the word is captured
    always_comb begin
        pop = '0;
        if (grant_valid && !reset) begin
            pop[grant_idx] = 1'b1;
        end
    end

    // Next-state: capture the winning word into its destination slot, count it, advance the pointer
    always_comb begin
        d_out_d  = d_out_q;
        d_push_d = '0;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        idle_d   = (&bus.vc_empty) & ~grant_valid;
        if (grant_valid) begin
            d_out_d[grant_dest*DATA_W +: DATA_W]  = grant_word;
            d_push_d[grant_dest]                  = 1'b1;
            cnt_d[grant_idx*CNT_W +: CNT_W]       = cnt_q[grant_idx*CNT_W +: CNT_W] + 1'b1;
            if (RR_MODE != 0) begin
                rr_ptr_d = (grant_idx == LAST_VC) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // State registers; reset drops any in-flight push immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out_q  <= '0;
            d_push_q <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            idle_q   <= 1'b1;
        end else begin
            d_out_q  <= d_out_d;
            d_push_q <= d_push_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            idle_q   <= idle_d;
        end
    end

    assign bus.vc_pop   = pop;
    assign bus.d_out    = d_out_q;
    assign bus.d_push   = d_push_q;
    assign bus.vc_count = cnt_q;
    assign bus.idle     = idle_q;
endmodule

// File: tb/tb_arbitro_enrutamiento_param.sv
// tb/tb_arbitro_enrutamiento_param.sv - strict and round-robin instances against a queue-based model
module tb_arbitro_enrutamiento_param;
    localparam int DW  = 6;
    localparam int NV  = 3;
    localparam int ND  = 4;
    localparam int DB  = 2;
    localparam int CW0 = 4;
    localparam int CW1 = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arbitro_enrutamiento_param_if #(.DATA_W(DW), .NUM_VC(NV), .NUM_DEST(ND), .CNT_W(CW0)) if_sp ();
    arbitro_enrutamiento_param_if #(.DATA_W(DW), .NUM_VC(NV), .NUM_DEST(ND), .CNT_W(CW1)) if_rr ();

    arbitro_enrutamiento_param #(.DATA_W(DW), .NUM_VC(NV), .NUM_DEST(ND), .DEST_BITS(DB),
                                 .RR_MODE(0), .CNT_W(CW0)) u_sp (.clk(clk), .reset(reset), .bus(if_sp));
    arbitro_enrutamiento_param #(.DATA_W(DW), .NUM_VC(NV), .NUM_DEST(ND), .DEST_BITS(DB),
                                 .RR_MODE(1), .CNT_W(CW1)) u_rr (.clk(clk), .reset(reset), .bus(if_rr));

    // Model: index 0 = strict instance, 1 = round-robin instance
    logic [DW-1:0] q [2][NV][$];
    logic [ND-1:0] pause [2];
    int            ptr [2];
    logic [ND-1:0] e_push [2];
    logic [DW-1:0] e_dout [2][ND];
    int            e_cnt [2][NV];
    logic          e_idle [2];
    int            grant [2];
    int            checks = 0;
    int            failures = 0;

    logic [DW-1:0] route_w [4];
    logic [DW-1:0] w;

    function automatic int dest_of(logic [DW-1:0] x);
        return int'(x[DW-1 -: DB]);
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < NV; v++) begin
                q[m][v].delete();
                e_cnt[m][v] = 0;
            end
            for (int d = 0; d < ND; d++) e_dout[m][d] = '0;
            pause[m]  = '0;
            ptr[m]    = 0;
            e_push[m] = '0;
            e_idle[m] = 1'b1;
            grant[m]  = -1;
        end
    endfunction

    function automatic int model_grant(int m);
        int start = (m == 1) ? ptr[1] : 0;
        for (int k = 0; k < NV; k++) begin
            int v = (start + k) % NV;
            if (q[m][v].size() != 0 && !pause[m][dest_of(q[m][v][0])]) return v;
        end
        return -1;
    endfunction

    function automatic void model_edge(int m);
        bit all_empty = 1'b1;
        logic [DW-1:0] x;
        for (int v = 0; v < NV; v++) if (q[m][v].size() != 0) all_empty = 1'b0;
        e_idle[m] = all_empty && (grant[m] < 0);
        e_push[m] = '0;
        if (grant[m] >= 0) begin
            x = q[m][grant[m]].pop_front();
            e_dout[m][dest_of(x)] = x;
            e_push[m][dest_of(x)] = 1'b1;
            e_cnt[m][grant[m]]++;
            if (m == 1) ptr[m] = (grant[m] + 1) % NV;
        end
    endfunction

    function automatic logic [63:0] exp_pop(int m);
        return (grant[m] >= 0) ? (64'(1) << grant[m]) : 64'(0);
    endfunction

    function automatic logic [63:0] exp_dout(int m);
        logic [63:0] r = '0;
        for (int d = 0; d < ND; d++) r |= 64'(e_dout[m][d]) << (d * DW);
        return r;
    endfunction

    function automatic logic [63:0] exp_cnt(int m);
        logic [63:0] r = '0;
        int cw = (m == 0) ? CW0 : CW1;
        for (int v = 0; v < NV; v++) r |= 64'(e_cnt[m][v] % (1 << cw)) << (v * cw);
        return r;
    endfunction

    function automatic logic [63:0] act_pop(int m);
        return (m == 0) ? 64'(if_sp.vc_pop) : 64'(if_rr.vc_pop);
    endfunction
    function automatic logic [63:0] act_push(int m);
        return (m == 0) ? 64'(if_sp.d_push) : 64'(if_rr.d_push);
    endfunction
    function automatic logic [63:0] act_dout(int m);
        return (m == 0) ? 64'(if_sp.d_out) : 64'(if_rr.d_out);
    endfunction
    function automatic logic [63:0] act_cnt(int m);
        return (m == 0) ? 64'(if_sp.vc_count) : 64'(if_rr.vc_count);
    endfunction
    function automatic logic [63:0] act_idle(int m);
        return (m == 0) ? 64'(if_sp.idle) : 64'(if_rr.idle);
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [NV*DW-1:0] dat [2];
        logic [NV-1:0]    emp [2];
        for (int m = 0; m < 2; m++) begin
            dat[m] = '0;
            emp[m] = '0;
            for (int v = 0; v < NV; v++) begin
                emp[m][v] = (q[m][v].size() == 0);
                if (!emp[m][v]) dat[m][v*DW +: DW] = q[m][v][0];
            end
        end
        if_sp.vc_data    = dat[0];
        if_sp.vc_empty   = emp[0];
        if_sp.dest_pause = pause[0];
        if_rr.vc_data    = dat[1];
        if_rr.vc_empty   = emp[1];
        if_rr.dest_pause = pause[1];
    endtask

    task automatic check_reset_state();
        for (int m = 0; m < 2; m++) begin
            string nm = (m == 0) ? "sp" : "rr";
            check({"rst_pop_", nm},  act_pop(m),  64'(0));
            check({"rst_push_", nm}, act_push(m), 64'(0));
            check({"rst_dout_", nm}, act_dout(m), 64'(0));
            check({"rst_cnt_", nm},  act_cnt(m),  64'(0));
            check({"rst_idle_", nm}, act_idle(m), 64'(1));
        end
    endtask

    // One clock cycle: starts and ends at a falling edge
    task automatic cycle();
        drive();
        #1;
        for (int m = 0; m < 2; m++) begin
            string nm = (m == 0) ? "sp" : "rr";
            grant[m] = model_grant(m);
            check({"vc_pop_", nm}, act_pop(m), exp_pop(m));
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            string nm = (m == 0) ? "sp" : "rr";
            model_edge(m);
            check({"d_push_", nm},   act_push(m), 64'(e_push[m]));
            check({"d_out_", nm},    act_dout(m), exp_dout(m));
            check({"vc_count_", nm}, act_cnt(m),  exp_cnt(m));
            check({"idle_", nm},     act_idle(m), 64'(e_idle[m]));
        end
        @(negedge clk);
    endtask

    // Asynchronous reset between clock edges, checked before any edge arrives
    task automatic do_reset();
        drive();
        #2;
        reset = 1'b1;
        #1;
        check_reset_state();
        model_reset();
        drive();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        drive();
        @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        reset = 1'b0;

        // Routing: one word to each destination from VC0
        route_w[0] = 6'h05;
        route_w[1] = 6'h15;
        route_w[2] = 6'h25;
        route_w[3] = 6'h35;
        for (int k = 0; k < 4; k++) q[0][0].push_back(route_w[k]);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("route_push", 64'(if_sp.d_push), 64'(1) << k);
            check("route_word", 64'(if_sp.d_out[k*DW +: DW]), 64'(route_w[k]));
        end
        cycle();

        // Reset mid-traffic
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 2; v++) begin
                q[0][v].push_back(6'($urandom_range(0, 63)));
                q[1][v].push_back(6'($urandom_range(0, 63)));
            end
        end
        cycle();
        cycle();
        do_reset();

        // Strict vs round-robin, same four words in VC0 and VC1
        for (int k = 0; k < 4; k++) begin
            for (int v = 0; v < 2; v++) begin
                w = 6'($urandom_range(0, 63));
                q[0][v].push_back(w);
                q[1][v].push_back(w);
            end
        end
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (k == 3) begin
                check("strict_cnt_half", 64'(if_sp.vc_count), 64'(12'h004));
                check("rr_cnt_half", 64'(if_rr.vc_count), 64'(24'h000202));
            end
        end
        check("strict_cnt_final", 64'(if_sp.vc_count), 64'(12'h044));
        check("rr_cnt_final", 64'(if_rr.vc_count), 64'(24'h000404));
        cycle();
        cycle();

        // Head-of-line: VC0 targets paused dest 1, VC1 proceeds to dest 2
        do_reset();
        pause[0] = 4'b0010;
        q[0][0].push_back(6'h12);
        q[0][1].push_back(6'h21);
        cycle();
        check("hol_push", 64'(if_sp.d_push), 64'(4'b0100));
        check("hol_cnt", 64'(if_sp.vc_count), 64'(12'h010));
        cycle();
        check("hol_held", 64'(if_sp.d_push), 64'(0));
        pause[0] = 4'b0000;
        cycle();
        check("hol_release_push", 64'(if_sp.d_push), 64'(4'b0010));
        check("hol_release_word", 64'(if_sp.d_out[DW +: DW]), 64'(6'h12));

        // Counter wrap on a 4-bit counter
        do_reset();
        for (int k = 0; k < 17; k++) q[0][1].push_back(6'($urandom_range(0, 63)));
        for (int k = 0; k < 17; k++) cycle();
        check("wrap_cnt", 64'(if_sp.vc_count), 64'(12'h010));
        cycle();

        // Random traffic with pauses and one reset
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                do_reset();
            end else begin
                for (int m = 0; m < 2; m++) begin
                    for (int v = 0; v < NV; v++) begin
                        if ($urandom_range(0, 2) != 0 && q[m][v].size() < 4)
                            q[m][v].push_back(6'($urandom_range(0, 63)));
                    end
                    pause[m] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
                end
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
